fb_pingpong_writer: RTL and testbench

FB_PINGPONG_WRITER -- requirements
Module: fb_pingpong_writer

---
 rtl/fb_pkg.sv | 19 +
 rtl/sat_counter.sv | 30 +++
 rtl/fb_pingpong_writer.sv | 209 ++++++++++++++++++++
 tb/tb_fb_pingpong_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg
// Shared definitions for the ping-pong framebuffer writer: frame geometry,
// datapath widths, event counter width and the writer FSM state type.
package fb_pkg;

  // 320x240 framebuffer, addressed linearly
  localparam int unsigned FB_PIXELS = 76800;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned PIX_W     = 7;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2,
    SKIP      = 2'd3
  } fb_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Event counter that increments by one per enabled cycle and sticks at its
// all-ones maximum instead of wrapping.
// Ports:
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset, clears the count
//   i_inc   - increment enable
//   o_count - current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fb_pingpong_writer.sv
// fb_pingpong_writer
// Writes rotated pixels into one bank of a double-buffered framebuffer while
// the display side reads the other bank. A bank swap happens only after a full
// frame has been written and the display side has released its bank; frames
// that cannot be written because no bank is free are dropped and counted.
// Ports:
//   clk_in, rst_in            - clock, synchronous active-low reset
//   pixel_in, pixel_addr_in   - pixel and framebuffer address from rotate stage
//   data_valid_in             - pixel/address qualifier
//   frame_start_in            - pulse at the first pixel time of a frame
//   read_done_in              - pulse: display side has finished with its bank
//   wr_en_out, wr_bank_out,
//   wr_addr_out, wr_data_out  - BRAM write port (one cycle behind the input)
//   rd_bank_out               - bank owned by the display side
//   frame_ready_out           - one-cycle pulse when the banks swap
//   dropped_frames_out,
//   short_frames_out,
//   oob_pixels_out            - saturating event counters
// FRAME_PIXELS sets the number of accepted writes that complete a frame; it
// defaults to the full framebuffer size.
module fb_pingpong_writer
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FB_PIXELS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PIX_W-1:0]     pixel_in,
  input  logic [FB_ADDR_W-1:0] pixel_addr_in,
  input  logic                 data_valid_in,
  input  logic                 frame_start_in,
  input  logic                 read_done_in,
  output logic                 wr_en_out,
  output logic                 wr_bank_out,
  output logic [FB_ADDR_W-1:0] wr_addr_out,
  output logic [PIX_W-1:0]     wr_data_out,
  output logic                 rd_bank_out,
  output logic                 frame_ready_out,
  output logic [CNT_W-1:0]     dropped_frames_out,
  output logic [CNT_W-1:0]     short_frames_out,
  output logic [CNT_W-1:0]     oob_pixels_out
);

  localparam logic [FB_ADDR_W-1:0] LP_ADDR_LIMIT = FB_ADDR_W'(FB_PIXELS);
  localparam logic [FB_ADDR_W-1:0] LP_LAST_IDX   = FB_ADDR_W'(FRAME_PIXELS - 1);

  fb_state_t            r_state;
  logic                 r_wrBank;
  logic                 r_rdBank;
  logic                 r_readerFree;
  logic [FB_ADDR_W-1:0] r_count;
  logic                 r_swap;
  logic                 r_wrEn;
  logic [FB_ADDR_W-1:0] r_wrAddr;
  logic [PIX_W-1:0]     r_wrData;
  logic                 r_wrBankOut;
  logic                 r_rdBankOut;
  logic                 r_frameReady;

  logic w_accept;
  logic w_oob;
  logic w_last;
  logic w_canSwap;
  logic w_dropInc;
  logic w_shortInc;
  logic w_oobInc;

  // Pixel classification and counter events for the current cycle. A frame
  // start that coincides with completion only counts as a drop when no swap
  // was possible; otherwise it simply begins the next frame.
  always_comb begin
    w_accept   = 1'b0;
    w_oob      = 1'b0;
    w_last     = 1'b0;
    w_canSwap  = r_readerFree | read_done_in;
    w_dropInc  = 1'b0;
    w_shortInc = 1'b0;
    w_oobInc   = 1'b0;
    if (r_state == WRITE) begin
      w_accept = data_valid_in && (pixel_addr_in < LP_ADDR_LIMIT);
      w_oob    = data_valid_in && (pixel_addr_in >= LP_ADDR_LIMIT);
    end
    w_last   = w_accept && (r_count == LP_LAST_IDX);
    w_oobInc = w_oob;
    unique case (r_state)
      WRITE: begin
        w_shortInc = frame_start_in && !w_last;
        w_dropInc  = frame_start_in && w_last && !w_canSwap;
      end
      WAIT_SWAP: w_dropInc = frame_start_in && !read_done_in;
      SKIP:      w_dropInc = frame_start_in;
      default:   ;
    endcase
  end

  // Writer FSM. The bank indicators and the swap pulse leave through the same
  // output register stage as the write port, so the last write of a frame is
  // still shown against the old bank and the two bank outputs change together
  // in the cycle frame_ready_out pulses; they can never be equal.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_wrBank     <= 1'b0;
      r_rdBank     <= 1'b1;
      r_readerFree <= 1'b1;
      r_count      <= '0;
      r_swap       <= 1'b0;
      r_wrEn       <= 1'b0;
      r_wrAddr     <= '0;
      r_wrData     <= '0;
      r_wrBankOut  <= 1'b0;
      r_rdBankOut  <= 1'b1;
      r_frameReady <= 1'b0;
    end else begin
      r_swap       <= 1'b0;
      r_wrEn       <= w_accept;
      r_wrBankOut  <= r_wrBank;
      r_rdBankOut  <= r_rdBank;
      r_frameReady <= r_swap;
      if (w_accept) begin
        r_wrAddr <= pixel_addr_in;
        r_wrData <= pixel_in;
      end
      // Any later swap in this cycle overrides this, which is how a
      // read_done_in arriving in the swap cycle gets ignored.
      if (read_done_in) begin
        r_readerFree <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (frame_start_in) begin
            r_state <= WRITE;
            r_count <= '0;
          end
        end
        WRITE: begin
          if (w_last) begin
            if (w_canSwap) begin
              r_rdBank     <= r_wrBank;
              r_wrBank     <= ~r_wrBank;
              r_readerFree <= 1'b0;
              r_swap       <= 1'b1;
              r_count      <= '0;
              r_state      <= frame_start_in ? WRITE : IDLE;
            end else begin
              r_state <= frame_start_in ? SKIP : WAIT_SWAP;
            end
          end else if (frame_start_in) begin
            r_count <= '0;
          end else if (w_accept) begin
            r_count <= r_count + 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (read_done_in) begin
            r_rdBank     <= r_wrBank;
            r_wrBank     <= ~r_wrBank;
            r_readerFree <= 1'b0;
            r_swap       <= 1'b1;
            r_count      <= '0;
            r_state      <= frame_start_in ? WRITE : IDLE;
          end else if (frame_start_in) begin
            r_state <= SKIP;
          end
        end
        SKIP: begin
          if (read_done_in) begin
            r_rdBank     <= r_wrBank;
            r_wrBank     <= ~r_wrBank;
            r_readerFree <= 1'b0;
            r_swap       <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_dropCnt (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_inc   (w_dropInc),
    .o_count (dropped_frames_out)
  );

  sat_counter #(.W(CNT_W)) u_shortCnt (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_inc   (w_shortInc),
    .o_count (short_frames_out)
  );

  sat_counter #(.W(CNT_W)) u_oobCnt (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_inc   (w_oobInc),
    .o_count (oob_pixels_out)
  );

  assign wr_en_out       = r_wrEn;
  assign wr_bank_out     = r_wrBankOut;
  assign wr_addr_out     = r_wrAddr;
  assign wr_data_out     = r_wrData;
  assign rd_bank_out     = r_rdBankOut;
  assign frame_ready_out = r_frameReady;

endmodule

// File: tb/tb_fb_pingpong_writer.sv
// tb_fb_pingpong_writer
// Scoreboard bench for fb_pingpong_writer. A behavioural model steps once per
// driven cycle and queues the writes and bank swaps it expects; a monitor on
// the falling edge pops and compares whenever the DUT writes or pulses
// frame_ready_out. The frame length is shortened so whole frames are cheap.
module tb_fb_pingpong_writer;
  import fb_pkg::*;

  localparam int unsigned FRAME = 64;
  localparam int M_IDLE = 0, M_WRITE = 1, M_WAIT = 2, M_SKIP = 3;

  typedef struct {
    logic                 bank;
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } wrEntry_t;

  logic                 clk = 1'b0;
  logic                 rstN;
  logic [PIX_W-1:0]     pixel;
  logic [FB_ADDR_W-1:0] pixelAddr;
  logic                 dataValid;
  logic                 frameStart;
  logic                 readDone;
  logic                 wrEnOut;
  logic                 wrBankOut;
  logic [FB_ADDR_W-1:0] wrAddrOut;
  logic [PIX_W-1:0]     wrDataOut;
  logic                 rdBankOut;
  logic                 frameReadyOut;
  logic [CNT_W-1:0]     droppedOut;
  logic [CNT_W-1:0]     shortOut;
  logic [CNT_W-1:0]     oobOut;

  int       checks = 0;
  int       errors = 0;
  bit       monOn  = 1'b0;
  wrEntry_t writeQ[$];
  bit       swapQ[$];

  int mMode, mCount, mDrop, mShort, mOob;
  bit mWrBank, mRdBank, mFree;

  always #5 clk = ~clk;

  fb_pingpong_writer #(.FRAME_PIXELS(FRAME)) dut (
    .clk_in             (clk),
    .rst_in             (rstN),
    .pixel_in           (pixel),
    .pixel_addr_in      (pixelAddr),
    .data_valid_in      (dataValid),
    .frame_start_in     (frameStart),
    .read_done_in       (readDone),
    .wr_en_out          (wrEnOut),
    .wr_bank_out        (wrBankOut),
    .wr_addr_out        (wrAddrOut),
    .wr_data_out        (wrDataOut),
    .rd_bank_out        (rdBankOut),
    .frame_ready_out    (frameReadyOut),
    .dropped_frames_out (droppedOut),
    .short_frames_out   (shortOut),
    .oob_pixels_out     (oobOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : 255;
  endfunction

  task automatic doSwap();
    swapQ.push_back(mWrBank);
    mRdBank = mWrBank;
    mWrBank = !mWrBank;
    mFree   = 1'b0;
  endtask

  // Reference behaviour for one clock of inputs, written from the frame rules:
  // count accepted pixels, swap banks when a full frame is in and the reader
  // has let go, otherwise wait or drop incoming frames.
  task automatic modelStep(input bit rst, input bit v, input logic [FB_ADDR_W-1:0] a,
                           input logic [PIX_W-1:0] p, input bit fs, input bit rd);
    bit       inRange;
    wrEntry_t e;
    if (!rst) begin
      mMode = M_IDLE; mCount = 0; mWrBank = 0; mRdBank = 1; mFree = 1;
      mDrop = 0; mShort = 0; mOob = 0;
      return;
    end
    inRange = v && (int'(a) < int'(FB_PIXELS));
    case (mMode)
      M_IDLE: begin
        if (rd) mFree = 1;
        if (fs) begin mMode = M_WRITE; mCount = 0; end
      end
      M_WRITE: begin
        if (v && !inRange) mOob = sat(mOob);
        if (inRange) begin
          e.bank = mWrBank; e.addr = a; e.data = p;
          writeQ.push_back(e);
          mCount++;
        end
        if (inRange && mCount == int'(FRAME)) begin
          if (mFree || rd) begin
            doSwap();
            mCount = 0;
            mMode  = fs ? M_WRITE : M_IDLE;
          end else if (fs) begin
            mMode = M_SKIP; mDrop = sat(mDrop);
          end else begin
            mMode = M_WAIT;
          end
        end else begin
          if (rd) mFree = 1;
          if (fs) begin mShort = sat(mShort); mCount = 0; end
        end
      end
      M_WAIT: begin
        if (rd) begin
          doSwap();
          mCount = 0;
          mMode  = fs ? M_WRITE : M_IDLE;
        end else if (fs) begin
          mMode = M_SKIP; mDrop = sat(mDrop);
        end
      end
      default: begin
        if (fs) mDrop = sat(mDrop);
        if (rd) begin doSwap(); mMode = M_IDLE; end
      end
    endcase
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [FB_ADDR_W-1:0] a,
                               input logic [PIX_W-1:0] p, input bit fs, input bit rd);
    rstN = rst; dataValid = v; pixelAddr = a; pixel = p; frameStart = fs; readDone = rd;
    modelStep(rst, v, a, p, fs, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, '0, '0, 0, 0);
  endtask

  task automatic sendPixels(input int n, input bit seqAddr);
    for (int i = 0; i < n; i++) begin
      if ($urandom % 4 == 0) idle(1);
      applyStimulus(1, 1, seqAddr ? FB_ADDR_W'(i) : FB_ADDR_W'($urandom % FB_PIXELS),
                    PIX_W'($urandom), 0, 0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wrEnOut), 0);
    checkOutput({tag, "_wr_bank"}, 32'(wrBankOut), 0);
    checkOutput({tag, "_wr_addr"}, 32'(wrAddrOut), 0);
    checkOutput({tag, "_wr_data"}, 32'(wrDataOut), 0);
    checkOutput({tag, "_rd_bank"}, 32'(rdBankOut), 1);
    checkOutput({tag, "_frame_ready"}, 32'(frameReadyOut), 0);
    checkOutput({tag, "_dropped"}, 32'(droppedOut), 0);
    checkOutput({tag, "_short"}, 32'(shortOut), 0);
    checkOutput({tag, "_oob"}, 32'(oobOut), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or announces a swap,
  // and watches that the two banks never coincide.
  always @(negedge clk) begin
    if (monOn) begin
      wrEntry_t e;
      bit       eb;
      checkOutput("bank_overlap", 32'(wrBankOut != rdBankOut), 1);
      if (wrEnOut) begin
        if (writeQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d expected no write at %0t", wrAddrOut, $time);
        end else begin
          e = writeQ.pop_front();
          checkOutput("wr_addr", 32'(wrAddrOut), 32'(e.addr));
          checkOutput("wr_data", 32'(wrDataOut), 32'(e.data));
          checkOutput("wr_bank", 32'(wrBankOut), 32'(e.bank));
        end
      end
      if (frameReadyOut) begin
        if (swapQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_frame_ready: got pulse expected none at %0t", $time);
        end else begin
          eb = swapQ.pop_front();
          checkOutput("swap_rd_bank", 32'(rdBankOut), 32'(eb));
          checkOutput("swap_wr_bank", 32'(wrBankOut), 32'(!eb));
        end
      end
    end
  end

  initial begin
    rstN = 0; dataValid = 0; pixelAddr = '0; pixel = '0; frameStart = 0; readDone = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, 0, 0);
    checkResetOutputs("reset");
    monOn = 1'b1;
    idle(2);

    // First full frame at sequential addresses; the reader starts out free.
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(FRAME, 1);
    idle(3);
    checkOutput("frame1_rd_bank", 32'(rdBankOut), 0);
    checkOutput("frame1_wr_bank", 32'(wrBankOut), 1);

    // Second frame with no read_done: waits, next start is dropped.
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(FRAME, 0);
    idle(2);
    applyStimulus(1, 0, '0, '0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, FB_ADDR_W'(i), PIX_W'($urandom), 0, 0);
    idle(2);
    checkOutput("skip_dropped", 32'(droppedOut), 1);
    checkOutput("skip_rd_bank", 32'(rdBankOut), 0);
    applyStimulus(1, 0, '0, '0, 0, 1);
    idle(3);
    checkOutput("late_swap_rd_bank", 32'(rdBankOut), 1);

    // Short frame restarts the count in the same bank.
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(20, 0);
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(FRAME, 0);
    idle(2);
    checkOutput("short_frames", 32'(shortOut), 1);
    applyStimulus(1, 0, '0, '0, 0, 1);
    idle(3);

    // Out-of-range addresses never reach the write port.
    applyStimulus(1, 0, '0, '0, 1, 0);
    applyStimulus(1, 1, FB_ADDR_W'(FB_PIXELS), 7'h55, 0, 0);
    applyStimulus(1, 1, 17'h1FFFF, 7'h2A, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, 1);
    sendPixels(FRAME, 0);
    idle(3);
    checkOutput("oob_pixels", 32'(oobOut), 2);

    // Completion, frame start and read_done together: swap, no drop.
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(FRAME - 1, 0);
    applyStimulus(1, 1, FB_ADDR_W'($urandom % FB_PIXELS), PIX_W'($urandom), 1, 1);
    idle(2);
    checkOutput("triple_no_drop", 32'(droppedOut), 1);
    sendPixels(FRAME, 0);
    idle(2);
    for (int i = 0; i < 301; i++) begin
      applyStimulus(1, 0, '0, '0, 1, 0);
      idle(1);
    end
    checkOutput("dropped_saturate", 32'(droppedOut), 255);
    applyStimulus(1, 0, '0, '0, 0, 1);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1, ($urandom % 10) < 7,
                    ($urandom % 20 == 0) ? FB_ADDR_W'(FB_PIXELS + ($urandom % 54272))
                                         : FB_ADDR_W'($urandom % FB_PIXELS),
                    PIX_W'($urandom), ($urandom % 150) == 0, ($urandom % 100) == 0);
    end
    idle(4);
    checkOutput("rand_dropped", 32'(droppedOut), 32'(mDrop));
    checkOutput("rand_short", 32'(shortOut), 32'(mShort));
    checkOutput("rand_oob", 32'(oobOut), 32'(mOob));
    checkOutput("rand_rd_bank", 32'(rdBankOut), 32'(mRdBank));

    // Reset in the middle of a frame abandons it without a swap.
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, '0, '0, 1, 0);
    sendPixels(30, 0);
    applyStimulus(0, 1, 17'd100, 7'h11, 0, 0);
    checkResetOutputs("midreset");
    idle(6);
    checkOutput("midreset_rd_bank_hold", 32'(rdBankOut), 1);

    checkOutput("writeQ_empty", 32'(writeQ.size()), 0);
    checkOutput("swapQ_empty", 32'(swapQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
